seq_detect_disp_top: RTL and testbench
======================================

Name: seq_detect_disp_top

Overview:
- Parametrised successor to the fixed-pattern birthday detector top.
- Single block containing:
  - a bit-serial pattern matcher with a runtime-loadable pattern of PAT_LEN bits and selectable overlapping/non-overlapping detection;
  - a saturating hit counter;
  - a sequential double-dabble binary-to-BCD converter;
  - a multiplexed 7-segment scan driver for DIGITS digits.
- Sits between the serial bit source and the board display.

Parameters:
- PAT_LEN, 8, pattern length in bits (2..64)
- PAT_INIT, 8'hA5, pattern loaded at reset (PAT_LEN bits wide)
- CNT_W, 6, hit counter width (4..16)
- DIGITS, 2, number of BCD digits displayed (1..5; 10^DIGITS-1 must be >= 2^CNT_W-1)
- SCAN_DIV, 10, i_clk cycles per displayed digit (>=2)

Ports:
- i_clk  in  1  system clock
- i_rst  in  1  reset, asynchronous, active-low
- i_bit  in  1  serial data bit
- i_bit_valid  in  1  qualifies i_bit for one cycle
- i_pat_load  in  1  high = shift i_pat_bit into the pattern register this cycle
- i_pat_bit  in  1  pattern bit, oldest-expected bit first
- i_mode_ovl  in  1  1 = overlapping detection, 0 = non-overlapping
- i_clr_count  in  1  synchronous clear of the hit counter
- o_hit  out  1  one-cycle pulse per detected pattern
- o_hit_count  out  CNT_W  saturating hit count
- o_hit_valid  out  1  high while the BCD digits reflect the current o_hit_count
- o_digit_sel  out  DIGITS  one-hot, active-low digit enable
- o_seg  out  7  segments {g,f,e,d,c,b,a}, active-low

Behaviour:

Reset (i_rst low):
- pattern = PAT_INIT; history and bits_seen = 0.
- o_hit = 0; o_hit_count = 0; o_hit_valid = 1; BCD digits = 0.
- Converter in IDLE; scan index = 0.
- o_digit_sel = {DIGITS{1}} except bit0 = 0; o_seg = glyph '0' (7'b1000000).
- Reset mid-conversion aborts the conversion.

Pattern load:
- Each cycle with i_pat_load = 1: pattern <= {pattern[PAT_LEN-2:0], i_pat_bit}.
- History and bits_seen are also cleared.
- i_bit_valid is ignored while i_pat_load = 1.
- A partial load of fewer than PAT_LEN bits leaves the upper bits from the previous pattern.

Matching:
- On i_bit_valid: history <= {history[PAT_LEN-2:0], i_bit}; bits_seen increments, saturating at PAT_LEN.
- Match = (next bits_seen == PAT_LEN) && (next history == pattern).
- o_hit is registered: it pulses the cycle after the matching valid bit (latency 1).
- Overlapping mode: history is kept after a hit.
- Non-overlapping mode: bits_seen is cleared on a hit, so the next hit needs PAT_LEN fresh bits.
- i_mode_ovl is sampled per bit; a change takes effect from the next valid bit.

Counter:
- Increments in the same cycle o_hit asserts.
- Saturates at 2^CNT_W-1; no wrap.
- If i_clr_count and a hit occur in the same cycle, clear wins and the count becomes 0.

BCD converter FSM:
- IDLE: on any change of o_hit_count, latch the count and go to CONV; o_hit_valid falls on that same edge.
- CONV: CNT_W iterations of add-3 (to any nibble >= 5) then shift left; one iteration per cycle.
- DONE: load the digit registers and raise o_hit_valid; return to IDLE.
- Total conversion latency is CNT_W+2 cycles from the count change to o_hit_valid.
- A count change during CONV/DONE sets a pending flag; conversion restarts from IDLE right after DONE, and o_hit_valid stays low until the restarted conversion completes.
- Displayed digits hold their previous values until DONE.

Scan:
- The prescaler counts 0..SCAN_DIV-1; on wrap, the scan index advances mod DIGITS.
- o_digit_sel drives bit[index] low; o_seg shows the glyph of BCD digit[index].
- Index 0 is the ones digit.
- Digit codes 10..15 cannot occur; they decode to all segments off.

Optional Feature:
- Macro LEAD_ZERO_BLANK_EN.
- Defined: any digit above index 0 that is zero and has only zero digits above it drives o_seg = 7'h7F (blank). The digit select still scans. The ones digit always displays.
- Undefined: all digits display, including leading zeros.

Test Plan:
- Reset with defaults, i_rst low 3 cycles then high -> o_hit_count=0, o_hit_valid=1, o_digit_sel=2'b10, o_seg=7'b1000000.
- PAT_LEN=4, load pattern 1,0,1,1; i_mode_ovl=1; stream 1011011 -> o_hit pulses after the 4th and 7th bits; o_hit_count=2.
- Same stream with i_mode_ovl=0 -> a single pulse after the 4th bit; o_hit_count=1.
- CNT_W=4, 17 hits -> o_hit_count saturates at 15. After o_hit_valid rises: digit1=1, digit0=5; o_digit_sel alternates 2'b10/2'b01 every SCAN_DIV cycles with o_seg 7'b0010010 / 7'b1111001.
- Hit on the 2nd cycle of an active conversion -> o_hit_valid stays low until the restarted conversion ends; final digits match the new count. A hit with simultaneous i_clr_count -> count 0.
- LEAD_ZERO_BLANK_EN defined, count 7 -> the tens slot shows 7'h7F and the ones slot shows 7'b1111000. With the macro undefined, the tens slot shows 7'b1000000.

Source files
------------

// File: rtl/seq_detect_disp_top.sv
// seq_detect_disp_top: serial pattern matcher, saturating hit counter, double-dabble BCD, 7-seg scan.
// Define LEAD_ZERO_BLANK_EN to blank leading-zero digits above the ones digit.
module seq_detect_disp_top #(
    parameter int                 PAT_LEN  = 8,
    parameter logic [PAT_LEN-1:0] PAT_INIT = 8'hA5,
    parameter int                 CNT_W    = 6,
    parameter int                 DIGITS   = 2,
    parameter int                 SCAN_DIV = 10
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_bit,
    input  logic              i_bit_valid,
    input  logic              i_pat_load,
    input  logic              i_pat_bit,
    input  logic              i_mode_ovl,
    input  logic              i_clr_count,
    output logic              o_hit,
    output logic [CNT_W-1:0]  o_hit_count,
    output logic              o_hit_valid,
    output logic [DIGITS-1:0] o_digit_sel,
    output logic [6:0]        o_seg
);
    localparam int SW = $clog2(PAT_LEN + 1);
    localparam int TW = $clog2(CNT_W);
    localparam int PW = $clog2(SCAN_DIV);
    localparam int IW = DIGITS > 1 ? $clog2(DIGITS) : 1;
    localparam int BW = 4 * DIGITS;
    localparam logic [SW-1:0]    SEEN_MAX  = SW'(PAT_LEN);
    localparam logic [TW-1:0]    ITER_LAST = TW'(CNT_W - 1);
    localparam logic [PW-1:0]    PRE_LAST  = PW'(SCAN_DIV - 1);
    localparam logic [IW-1:0]    IDX_LAST  = IW'(DIGITS - 1);
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;

    typedef enum logic [1:0] {IDLE, CONV, DONE} state_t;

    state_t              state_q, state_d;
    logic [PAT_LEN-1:0]  pat_q, pat_d, hist_q, hist_d, hist_nx;
    logic [SW-1:0]       seen_q, seen_d, seen_nx;
    logic                match, hit_q, chg_q, pend_q, pend_d, valid_q, valid_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [TW-1:0]       iter_q, iter_d;
    logic [BW+CNT_W-1:0] sh_q, sh_d, adj;
    logic [BW-1:0]       dig_q, dig_d;
    logic [PW-1:0]       pre_q, pre_d;
    logic [IW-1:0]       idx_q, idx_d;
    logic [3:0]          cur;

    assign hist_nx = {hist_q[PAT_LEN-2:0], i_bit};
    assign seen_nx = seen_q == SEEN_MAX ? seen_q : seen_q + 1'b1;
    assign match   = i_bit_valid && !i_pat_load && seen_nx == SEEN_MAX && hist_nx == pat_q;
    assign pat_d   = i_pat_load ? {pat_q[PAT_LEN-2:0], i_pat_bit} : pat_q;
    assign hist_d  = i_pat_load ? '0 : i_bit_valid ? hist_nx : hist_q;
    // Non-overlapping mode forgets the bit count so the next hit needs PAT_LEN fresh bits.
    assign seen_d  = i_pat_load ? '0 : !i_bit_valid ? seen_q : (match && !i_mode_ovl) ? '0 : seen_nx;
    assign cnt_d   = i_clr_count ? '0 : (match && cnt_q != CNT_MAX) ? cnt_q + 1'b1 : cnt_q;

    always_comb begin
        adj = sh_q;
        for (int k = 0; k < DIGITS; k++)
            if (sh_q[CNT_W+4*k +: 4] >= 4'd5) adj[CNT_W+4*k +: 4] = sh_q[CNT_W+4*k +: 4] + 4'd3;
    end

    always_comb begin
        state_d = state_q;
        iter_d  = iter_q;
        sh_d    = sh_q;
        dig_d   = dig_q;
        valid_d = valid_q;
        pend_d  = pend_q;
        case (state_q)
            IDLE: if (chg_q || pend_q) begin
                state_d = CONV;
                iter_d  = '0;
                sh_d    = {{BW{1'b0}}, cnt_q};
                valid_d = 1'b0;
                pend_d  = 1'b0;
            end
            CONV: begin
                sh_d    = adj << 1;
                iter_d  = iter_q + 1'b1;
                pend_d  = pend_q || chg_q;
                state_d = iter_q == ITER_LAST ? DONE : CONV;
            end
            DONE: begin
                dig_d   = sh_q[BW+CNT_W-1:CNT_W];
                valid_d = !(pend_q || chg_q);
                pend_d  = pend_q || chg_q;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign pre_d = pre_q == PRE_LAST ? '0 : pre_q + 1'b1;
    assign idx_d = pre_q != PRE_LAST ? idx_q : idx_q == IDX_LAST ? '0 : idx_q + 1'b1;

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            pat_q   <= PAT_INIT;
            hist_q  <= '0;
            seen_q  <= '0;
            hit_q   <= 1'b0;
            cnt_q   <= '0;
            chg_q   <= 1'b0;
            pend_q  <= 1'b0;
            state_q <= IDLE;
            iter_q  <= '0;
            sh_q    <= '0;
            dig_q   <= '0;
            valid_q <= 1'b1;
            pre_q   <= '0;
            idx_q   <= '0;
        end else begin
            pat_q   <= pat_d;
            hist_q  <= hist_d;
            seen_q  <= seen_d;
            hit_q   <= match;
            cnt_q   <= cnt_d;
            chg_q   <= cnt_d != cnt_q;
            pend_q  <= pend_d;
            state_q <= state_d;
            iter_q  <= iter_d;
            sh_q    <= sh_d;
            dig_q   <= dig_d;
            valid_q <= valid_d;
            pre_q   <= pre_d;
            idx_q   <= idx_d;
        end
    end

    function automatic logic [6:0] glyph(input logic [3:0] d);
        case (d)
            4'd0:    glyph = 7'b1000000;
            4'd1:    glyph = 7'b1111001;
            4'd2:    glyph = 7'b0100100;
            4'd3:    glyph = 7'b0110000;
            4'd4:    glyph = 7'b0011001;
            4'd5:    glyph = 7'b0010010;
            4'd6:    glyph = 7'b0000010;
            4'd7:    glyph = 7'b1111000;
            4'd8:    glyph = 7'b0000000;
            4'd9:    glyph = 7'b0010000;
            default: glyph = 7'h7F;
        endcase
    endfunction

    always_comb begin
        cur = dig_q[3:0];
        for (int k = 0; k < DIGITS; k++)
            if (IW'(k) == idx_q) cur = dig_q[4*k +: 4];
    end

`ifdef LEAD_ZERO_BLANK_EN
    logic lz, blank;
    // A digit is blank when it and every digit above it are zero.
    always_comb begin
        lz    = 1'b1;
        blank = 1'b0;
        for (int k = DIGITS - 1; k > 0; k--) begin
            lz = lz && dig_q[4*k +: 4] == 4'd0;
            if (IW'(k) == idx_q) blank = lz;
        end
    end
    assign o_seg = blank ? 7'h7F : glyph(cur);
`else
    assign o_seg = glyph(cur);
`endif

    assign o_hit       = hit_q;
    assign o_hit_count = cnt_q;
    assign o_hit_valid = valid_q;
    assign o_digit_sel = ~(DIGITS'(1) << idx_q);
endmodule

// File: tb/tb_seq_detect_disp_top.sv
// tb_seq_detect_disp_top: scoreboard bench; a queue of expected hits is popped by a monitor,
// and a bit-window reference model supplies count, display and conversion-timing expectations.
module tb_seq_detect_disp_top;
    localparam int PL = 4, CW = 4, ND = 2, SD = 4;
    localparam logic [PL-1:0] PINIT = 4'hA;
    localparam int CMAX = (1 << CW) - 1;

    logic clk = 0, rst_n = 0, bit_i = 0, bv = 0, pl = 0, pb = 0, ovl = 1, clr = 0;
    logic hit, hval;
    logic [CW-1:0] hcnt;
    logic [ND-1:0] sel;
    logic [6:0] seg;

    seq_detect_disp_top #(.PAT_LEN(PL), .PAT_INIT(PINIT), .CNT_W(CW), .DIGITS(ND), .SCAN_DIV(SD)) dut (
        .i_clk(clk), .i_rst(rst_n), .i_bit(bit_i), .i_bit_valid(bv), .i_pat_load(pl),
        .i_pat_bit(pb), .i_mode_ovl(ovl), .i_clr_count(clr), .o_hit(hit), .o_hit_count(hcnt),
        .o_hit_valid(hval), .o_digit_sel(sel), .o_seg(seg));

    always #5 clk = ~clk;

    typedef struct { int cyc; int cnt; } hit_t;
    hit_t hq[$];
    hit_t me;
    bit mpat[$], mwin[$];
    int mcnt, mcnt_nx, mstable, mprev, cyc = 0, rcyc = 0, rgap = 0;
    int n_cmp = 0, n_bad = 0;
    bit rchk = 0;
    logic [6:0] gly [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                             7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};

    always @(posedge clk) cyc <= cyc + 1;
    always @(posedge clk or negedge rst_n) rcyc <= !rst_n ? 0 : rcyc + 1;

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic logic [6:0] exp_seg(input int c, input int idx);
`ifdef LEAD_ZERO_BLANK_EN
        if (idx > 0 && c < 10 ** idx) return 7'h7F;
`endif
        return gly[(c / (10 ** idx)) % 10];
    endfunction

    task automatic model_reset();
        mpat.delete();
        for (int i = PL - 1; i >= 0; i--) mpat.push_back(PINIT[i]);
        mwin.delete();
        hq.delete();
        mcnt = 0; mcnt_nx = 0; mstable = 1000; mprev = 1000;
    endtask

    // Commit the model at the edge, then drive the next inputs and predict their effect.
    task automatic step(input logic v, input logic b, input logic l, input logic p, input logic o, input logic c);
        bit h;
        @(posedge clk);
        if (mcnt_nx != mcnt) begin mprev = mstable; mstable = 0; end
        else mstable++;
        mcnt = mcnt_nx;
        #1;
        bv = v; bit_i = b; pl = l; pb = p; ovl = o; clr = c;
        h = 0;
        if (l) begin
            mpat.push_back(p);
            if (mpat.size() > PL) void'(mpat.pop_front());
            mwin.delete();
        end else if (v) begin
            mwin.push_back(b);
            if (mwin.size() > PL) void'(mwin.pop_front());
            if (mwin.size() == PL) begin
                h = 1;
                for (int i = 0; i < PL; i++) if (mwin[i] != mpat[i]) h = 0;
            end
            if (h && !o) mwin.delete();
        end
        mcnt_nx = c ? 0 : h ? (mcnt == CMAX ? CMAX : mcnt + 1) : mcnt;
        if (h) hq.push_back('{cyc + 1, mcnt_nx});
    endtask

    task automatic idle(input int n);
        repeat (n) step(0, 0, 0, 0, ovl, 0);
    endtask

    task automatic sendbits(input logic [31:0] v, input int n, input logic o);
        for (int i = n - 1; i >= 0; i--) step(1, v[i], 0, 0, o, 0);
    endtask

    task automatic loadpat(input logic [PL-1:0] p);
        for (int i = PL - 1; i >= 0; i--) step(0, 0, 1, p[i], ovl, 0);
    endtask

    task automatic check_slots(input string nm, input logic [6:0] ones, input logic [6:0] tens);
        bit s0, s1;
        s0 = 0; s1 = 0;
        idle(2 * CW + 8);
        chk({nm, "_valid"}, hval, 1);
        for (int i = 0; i < 2 * SD * ND; i++) begin
            idle(1);
            if (sel == 2'b10 && !s0) begin chk({nm, "_ones"}, seg, ones); s0 = 1; end
            if (sel == 2'b01 && !s1) begin chk({nm, "_tens"}, seg, tens); s1 = 1; end
        end
        chk({nm, "_scanned"}, s0 && s1, 1);
    endtask

    task automatic reset_checks(input string nm);
        chk({nm, "_count"}, hcnt, 0);
        chk({nm, "_valid"}, hval, 1);
        chk({nm, "_hit"}, hit, 0);
        chk({nm, "_sel"}, sel, 2'b10);
        chk({nm, "_seg"}, seg, 7'b1000000);
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            automatic int eidx = (rcyc / SD) % ND;
            automatic logic [ND-1:0] es = ~(ND'(1) << eidx);
            while (hq.size() > 0 && hq[0].cyc < cyc) begin
                me = hq.pop_front();
                chk("hit_missing", cyc, me.cyc);
            end
            if (hit) begin
                if (hq.size() == 0) chk("hit_spurious", 1, 0);
                else begin
                    me = hq.pop_front();
                    chk("hit_cycle", cyc, me.cyc);
                    chk("hit_count", hcnt, me.cnt);
                end
            end
            chk("count", hcnt, mcnt);
            chk("digit_sel", sel, es);
            if (mstable >= 1 && mstable <= CW + 1) chk("valid_low", hval, 0);
            if ((mstable == CW + 2 && mprev >= 2 * CW + 5) || mstable >= 2 * CW + 5) chk("valid_high", hval, 1);
            if (rchk && mstable >= 1 && mstable < rgap) chk("restart_low", hval, 0);
            if (rchk && mstable == rgap) chk("restart_high", hval, 1);
            if (hval && mstable >= 1) chk("seg", seg, exp_seg(mcnt, eidx));
        end
    end

    initial begin
        #2000000;
        $display("FAIL timeout: bench did not complete");
        $fatal(1);
    end

    initial begin
        model_reset();
        repeat (3) @(posedge clk);
        @(negedge clk); #2 rst_n = 1;
        #1 reset_checks("reset");

        loadpat(4'b1011);
        sendbits(7'b1011011, 7, 1);
        idle(20);
        chk("ovl_count", hcnt, 2);

        loadpat(4'b1011);
        step(0, 0, 0, 0, 0, 1);
        sendbits(7'b1011011, 7, 0);
        idle(20);
        chk("novl_count", hcnt, 1);

        loadpat(4'b1011);
        step(0, 0, 0, 0, 1, 1);
        sendbits(4'b1011, 4, 1);
        repeat (16) sendbits(3'b011, 3, 1);
        idle(1);
        chk("sat_count", hcnt, 15);
        check_slots("sat", 7'b0010010, 7'b1111001);

        // Second count change lands while the first conversion is running.
        step(0, 0, 0, 0, 1, 1);
        loadpat(4'b1011);
        idle(20);
        sendbits(7'b1011011, 7, 1);
        idle(1);
        rgap = 2 * (CW + 2) - 3;
        rchk = 1;
        idle(2 * CW + 8);
        rchk = 0;
        chk("restart_count", hcnt, 2);
        check_slots("restart", 7'b0100100,
`ifdef LEAD_ZERO_BLANK_EN
            7'h7F);
`else
            7'b1000000);
`endif

        loadpat(4'b1011);
        sendbits(3'b101, 3, 1);
        step(1, 1, 0, 0, 1, 1);
        idle(1);
        chk("clr_wins", hcnt, 0);

        loadpat(4'b1011);
        sendbits(4'b1011, 4, 1);
        repeat (6) sendbits(3'b011, 3, 1);
        idle(1);
        chk("seven_count", hcnt, 7);
        check_slots("seven", 7'b1111000,
`ifdef LEAD_ZERO_BLANK_EN
            7'h7F);
`else
            7'b1000000);
`endif

        sendbits(3'b011, 3, 1);
        idle(2);
        @(negedge clk); #2 rst_n = 0;
        model_reset();
        #1 reset_checks("midreset");
        repeat (3) @(negedge clk);
        #2 rst_n = 1;
        #1 reset_checks("release");

        begin
            automatic logic ro = 1;
            for (int i = 0; i < 3000; i++) begin
                if ($urandom_range(19) == 0) ro = !ro;
                step($urandom_range(1), $urandom_range(1), $urandom_range(39) == 0,
                     $urandom_range(1), ro, $urandom_range(59) == 0);
            end
        end
        idle(40);
        chk("queue_empty", hq.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
